// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the fetch front end.
package cpu_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] instr_t;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        OUT,
        DRAIN
    } fetch_state_t;

    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;

endpackage

// File: rtl/call_ret_predecode.sv
// Combinational CALL/RET predecode and next-PC selection for one fetched instruction.
module call_ret_predecode
    import cpu_pkg::*;
#(
    parameter logic [3:0] CALL_OP = OP_CALL,
    parameter logic [3:0] RET_OP  = OP_RET
) (
    input  instr_t instr,
    input  addr_t  pc,
    input  addr_t  ras_top,
    input  logic   ras_err,
    output logic   is_call,
    output logic   is_ret,
    output addr_t  next_pc,
    output addr_t  push_data,
    output logic   underflow
);

    addr_t pc_inc;
    addr_t call_target;

    // Both sums wrap naturally at 16 bits.
    assign pc_inc      = pc + 16'd1;
    assign call_target = pc + {{4{instr[11]}}, instr[11:0]};

    assign is_call   = (instr[15:12] == CALL_OP);
    assign is_ret    = (instr[15:12] == RET_OP);
    assign push_data = pc_inc;
    assign underflow = is_ret && ras_err;

    always_comb begin
        next_pc = pc_inc;
        if (is_call) begin
            next_pc = call_target;
        end else if (is_ret && !ras_err) begin
            next_pc = ras_top;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: owns the fetch PC, talks to imem, and drives the RAS.
//   state | meaning
//   BOOT  | one idle cycle after reset release
//   REQ   | imem request for pc outstanding
//   WAIT  | waiting for the returned instruction; predecode on arrival
//   OUT   | instruction held for decode until not stalled
//   DRAIN | swallow the response of a request made stale by a redirect
module fetch_pc_gen
    import cpu_pkg::*;
#(
    parameter addr_t      RESET_PC = 16'h0000,
    parameter logic [3:0] CALL_OP  = OP_CALL,
    parameter logic [3:0] RET_OP   = OP_RET
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   redirect_valid,
    input  addr_t  redirect_pc,
    output logic   imem_req,
    output addr_t  imem_addr,
    input  logic   imem_rdy,
    input  logic   instr_valid,
    input  instr_t instr_in,
    output logic   out_valid,
    output instr_t instr_out,
    output addr_t  pc_out,
    output logic   ras_push,
    output addr_t  ras_new_data,
    output logic   ras_pop,
    input  addr_t  ras_top,
    input  logic   ras_err,
    output logic   ras_underflow
);

    fetch_state_t state;
    addr_t        pc;

    logic  pd_is_call;
    logic  pd_is_ret;
    logic  pd_underflow;
    addr_t pd_next_pc;
    addr_t pd_push_data;
    logic  take_instr;

    call_ret_predecode #(
        .CALL_OP (CALL_OP),
        .RET_OP  (RET_OP)
    ) u_predecode (
        .instr     (instr_in),
        .pc        (pc),
        .ras_top   (ras_top),
        .ras_err   (ras_err),
        .is_call   (pd_is_call),
        .is_ret    (pd_is_ret),
        .next_pc   (pd_next_pc),
        .push_data (pd_push_data),
        .underflow (pd_underflow)
    );

    // A redirect in the same cycle kills the instruction, including its RAS side effects.
    assign take_instr    = (state == WAIT) && instr_valid && !redirect_valid;
    assign ras_push      = take_instr && pd_is_call;
    assign ras_pop       = take_instr && pd_is_ret;
    assign ras_new_data  = ras_push ? pd_push_data : 16'h0000;
    assign ras_underflow = ras_pop && pd_underflow;
    assign imem_addr     = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            instr_out <= '0;
            pc_out    <= '0;
            imem_req  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (imem_rdy) begin
                            state    <= DRAIN;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_rdy) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        state    <= instr_valid ? REQ : DRAIN;
                        imem_req <= instr_valid;
                    end else if (instr_valid) begin
                        pc        <= pd_next_pc;
                        instr_out <= instr_in;
                        pc_out    <= pc;
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        out_valid <= 1'b0;
                    end else if (!stall) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    // Leaving on the stale response also covers a redirect arriving with it.
                    if (instr_valid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state     <= BOOT;
                    imem_req  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: directed program in a memory model, queued expectations.
module tb_fetch_pc_gen;
    import cpu_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   stall;
    logic   redirect_valid;
    addr_t  redirect_pc;
    logic   imem_req;
    addr_t  imem_addr;
    logic   imem_rdy;
    logic   instr_valid;
    instr_t instr_in;
    logic   out_valid;
    instr_t instr_out;
    addr_t  pc_out;
    logic   ras_push;
    addr_t  ras_new_data;
    logic   ras_pop;
    addr_t  ras_top;
    logic   ras_err;
    logic   ras_underflow;

    fetch_pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .instr_valid    (instr_valid),
        .instr_in       (instr_in),
        .out_valid      (out_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .ras_push       (ras_push),
        .ras_new_data   (ras_new_data),
        .ras_pop        (ras_pop),
        .ras_top        (ras_top),
        .ras_err        (ras_err),
        .ras_underflow  (ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        int          gap;
    } out_exp_t;

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] data;
        logic        uf;
    } ras_exp_t;

    out_exp_t    out_q[$];
    ras_exp_t    ras_q[$];
    logic [15:0] addr_q[$];
    logic [15:0] mem [logic [15:0]];

    int checks   = 0;
    int failures = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Memory responder: answers an accepted request after a per-address latency.
    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          pend_cnt = 0;

    always @(negedge clk) begin
        instr_valid = 1'b0;
        ras_err     = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && pend_cnt == 0) begin
                instr_valid = 1'b1;
                instr_in    = mem_rd(pend_addr);
                ras_err     = (pend_addr == 16'h0030);
                pend        = 1'b0;
            end else if (pend) begin
                pend_cnt--;
            end
            if (imem_req && imem_rdy) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                pend_cnt  = (imem_addr == 16'h0032) ? 1 : 0;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a request, output or RAS op.
    int cyc = 0;
    int last_acc = 0;

    always @(negedge clk) begin
        logic [15:0] ea;
        out_exp_t    eo;
        ras_exp_t    er;
        #2;
        cyc++;
        if (!rst) begin
            if (imem_req && imem_rdy) begin
                if (addr_q.size() == 0) unexpected("imem_addr", imem_addr);
                else begin
                    ea = addr_q.pop_front();
                    chk16("imem_addr", imem_addr, ea);
                end
            end
            if (out_valid && !stall) begin
                if (out_q.size() == 0) unexpected("pc_out", pc_out);
                else begin
                    eo = out_q.pop_front();
                    chk16("pc_out", pc_out, eo.pc);
                    chk16("instr_out", instr_out, eo.instr);
                    if (eo.gap != 0) chk_int("out_gap", cyc - last_acc, eo.gap);
                end
                last_acc = cyc;
            end
            if (ras_push || ras_pop) begin
                if (ras_q.size() == 0) unexpected("ras_op", {14'b0, ras_push, ras_pop});
                else begin
                    er = ras_q.pop_front();
                    chk1("ras_push", ras_push, er.push);
                    chk1("ras_pop", ras_pop, er.pop);
                    if (er.push) chk16("ras_new_data", ras_new_data, er.data);
                    chk1("ras_underflow", ras_underflow, er.uf);
                end
            end else if (ras_underflow) begin
                chk1("ras_underflow_stray", ras_underflow, 1'b0);
            end
        end
    end

    task automatic wait_out(input logic [15:0] pc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (out_valid && pc_out == pc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_out: no output at pc %h", pc);
        end
    endtask

    task automatic wait_accept(input logic [15:0] a, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (imem_req && imem_rdy && imem_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_req: no request at %h", a);
        end
    endtask

    initial begin
        logic ok;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_rdy       = 1'b1;
        instr_in       = 16'h0000;
        ras_top        = 16'h0011;

        mem[16'h0000] = 16'h1000;
        mem[16'h0001] = 16'h2000;
        mem[16'h0002] = 16'h3000;
        mem[16'h0003] = 16'hC00D;
        mem[16'h0010] = 16'hC005;
        mem[16'h0015] = 16'hC00B;
        mem[16'h0020] = 16'hD000;
        mem[16'h0011] = 16'hC01F;
        mem[16'h0030] = 16'hD000;
        mem[16'h0031] = 16'h0000;
        mem[16'h0032] = 16'hC005;
        mem[16'h0100] = 16'h5555;
        mem[16'hFFFF] = 16'h1234;

        addr_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0015, 16'h0020,
                   16'h0011, 16'h0030, 16'h0031, 16'h0032, 16'h0100, 16'hFFFF, 16'h0000};
        out_q.push_back('{16'h0000, 16'h1000, 0});
        out_q.push_back('{16'h0001, 16'h2000, 3});
        out_q.push_back('{16'h0002, 16'h3000, 3});
        out_q.push_back('{16'h0003, 16'hC00D, 0});
        out_q.push_back('{16'h0010, 16'hC005, 0});
        out_q.push_back('{16'h0015, 16'hC00B, 0});
        out_q.push_back('{16'h0020, 16'hD000, 0});
        out_q.push_back('{16'h0011, 16'hC01F, 0});
        out_q.push_back('{16'h0030, 16'hD000, 0});
        out_q.push_back('{16'h0031, 16'h0000, 0});
        out_q.push_back('{16'hFFFF, 16'h1234, 0});
        out_q.push_back('{16'h0000, 16'h1000, 0});
        ras_q.push_back('{1'b1, 1'b0, 16'h0004, 1'b0});
        ras_q.push_back('{1'b1, 1'b0, 16'h0011, 1'b0});
        ras_q.push_back('{1'b1, 1'b0, 16'h0016, 1'b0});
        ras_q.push_back('{1'b0, 1'b1, 16'h0000, 1'b0});
        ras_q.push_back('{1'b1, 1'b0, 16'h0012, 1'b0});
        ras_q.push_back('{1'b0, 1'b1, 16'h0000, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_ras_push", ras_push, 1'b0);
        chk1("rst_ras_pop", ras_pop, 1'b0);
        chk1("rst_ras_underflow", ras_underflow, 1'b0);
        chk16("rst_instr_out", instr_out, 16'h0000);
        chk16("rst_pc_out", pc_out, 16'h0000);
        chk16("rst_imem_addr", imem_addr, 16'h0000);
        rst = 1'b0;
        chk1("boot_imem_req", imem_req, 1'b0);

        // Stall in OUT: the held output must not move and no request may issue.
        wait_out(16'h0031, ok);
        if (ok) begin
            stall = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                chk16("stall_pc_out", pc_out, 16'h0031);
                chk16("stall_instr_out", instr_out, 16'h0000);
                chk1("stall_out_valid", out_valid, 1'b1);
                chk1("stall_imem_req", imem_req, 1'b0);
            end
            stall = 1'b0;
        end

        // Redirect while WAIT has no response yet: the late CALL must be swallowed.
        wait_accept(16'h0032, ok);
        if (ok) begin
            @(posedge clk); #1;
            redirect_valid = 1'b1;
            redirect_pc    = 16'h0100;
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            chk1("drain_imem_req", imem_req, 1'b0);
            chk1("drain_out_valid", out_valid, 1'b0);
        end

        // Redirect together with stall in OUT: redirect wins.
        wait_out(16'h0100, ok);
        if (ok) begin
            stall          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = 16'hFFFF;
            @(posedge clk); #1;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            chk1("redir_stall_out_valid", out_valid, 1'b0);
            chk1("redir_stall_imem_req", imem_req, 1'b1);
            chk16("redir_stall_imem_addr", imem_addr, 16'hFFFF);
        end

        for (int i = 0; i < 300 && addr_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        imem_rdy = 1'b0;
        for (int i = 0; i < 300 && out_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        #1;
        chk_int("addr_q_left", addr_q.size(), 0);
        chk_int("out_q_left", out_q.size(), 0);
        chk_int("ras_q_left", ras_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
